// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// The state encodings and owner-select codes are imported by the arbiter top.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic CTL_ARB_OWNER_I = 1'b0;
    localparam logic CTL_ARB_OWNER_D = 1'b1;

    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
        return (val >= lim) ? lim : val + 4'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency memory bus.
// Data wins ties unless fetch has been starved; in-flight accesses can time out.
//
//   state      | meaning
//   ARB_IDLE   | bus idle, arbitration on the next edge
//   ARB_BUSY_I | fetch transaction waiting for m_ack
//   ARB_BUSY_D | data transaction waiting for m_ack
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                bus_error,
    output logic                busy
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST    = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic       TO_EN      = (TIMEOUT != 0);

    arb_state_t          r_state, w_state_nxt;
    logic [3:0]          r_starve_cnt;
    logic [7:0]          r_to_cnt;
    logic                r_m_req;
    logic                r_m_we;
    logic [DATA_W/8-1:0] r_m_be;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;

    logic w_busy;
    logic w_ack;
    logic w_expire;
    logic w_done;
    logic w_grant_d;
    logic w_grant_i;
    logic w_sel;

    always_comb begin
        w_busy    = (r_state != ARB_IDLE);
        w_ack     = w_busy && m_ack;
        // A coincident ack takes precedence over expiry.
        w_expire  = TO_EN && w_busy && !m_ack && (r_to_cnt == TO_LAST);
        w_done    = w_ack || w_expire;
        w_grant_d = (r_state == ARB_IDLE) && d_req && (!i_req || (r_starve_cnt < STARVE_MAX));
        w_grant_i = (r_state == ARB_IDLE) && !w_grant_d && i_req;
        w_sel     = w_grant_d ? CTL_ARB_OWNER_D : CTL_ARB_OWNER_I;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_d)      w_state_nxt = ARB_BUSY_D;
                else if (w_grant_i) w_state_nxt = ARB_BUSY_I;
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (w_done) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_to_cnt     <= '0;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_be       <= '0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
        end else begin
            if (w_grant_d || w_grant_i) begin
                r_to_cnt <= '0;
                r_m_req  <= 1'b1;
                if (w_sel == CTL_ARB_OWNER_D) begin
                    r_m_we    <= d_we;
                    r_m_be    <= d_we ? d_be : '1;
                    r_m_addr  <= d_addr;
                    r_m_wdata <= d_wdata;
                end else begin
                    r_m_we    <= 1'b0;
                    r_m_be    <= '1;
                    r_m_addr  <= i_addr;
                    r_m_wdata <= '0;
                end
            end else if (w_busy) begin
                if (w_done) begin
                    r_m_req <= 1'b0;
                end else if (r_to_cnt != 8'hFF) begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                end
            end

            if (w_grant_i) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && i_req) begin
                r_starve_cnt <= sat_inc4(r_starve_cnt, STARVE_MAX);
            end
        end
    end

    always_comb begin
        busy      = w_busy;
        m_req     = r_m_req;
        m_we      = r_m_we;
        m_be      = r_m_be;
        m_addr    = r_m_addr;
        m_wdata   = r_m_wdata;
        bus_error = w_expire;
        i_ready   = (r_state == ARB_BUSY_I) && w_done;
        d_ready   = (r_state == ARB_BUSY_D) && w_done;
        i_rdata   = ((r_state == ARB_BUSY_I) && w_ack) ? m_rdata : '0;
        d_rdata   = ((r_state == ARB_BUSY_D) && w_ack) ? m_rdata : '0;
    end

endmodule
